qsfp_xcvr_reset_seq: RTL and testbench

Reset/bring-up sequencer for the QSFP native transceiver lanes and their shared ATX PLL. It releases PLL powerdown, waits for PLL lock, and walks each lane through TX and RX analog/digital reset release in the order the S10 native PHY requires. It re-sequences any lane that loses CDR lock or PLL lock, and counts per-lane relock events for status readout. It sits beside the q_sys transceiver instances in the 100 MHz domain and replaces the ad-hoc reset wiring.

---
 rtl/qsfp_xcvr_pkg.sv | 32 +++
 rtl/qsfp_lane_seq.sv | 174 +++++++++++++++++
 rtl/qsfp_xcvr_reset_seq.sv | 111 +++++++++++
 tb/tb_qsfp_xcvr_reset_seq.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qsfp_xcvr_pkg.sv
// Shared types and constants for the QSFP transceiver reset sequencer.
//   pll_state_t : shared ATX PLL bring-up states
//   tx_state_t  : per-lane TX reset release states
//   rx_state_t  : per-lane RX reset release states
//   RELOCK_W    : width of each lane's saturating lock-loss counter
//   SYNC_DEPTH  : flops in every asynchronous-input synchronizer
package qsfp_xcvr_pkg;

   typedef enum logic [1:0] {
      PLL_PD        = 2'd0,
      PLL_WAIT_LOCK = 2'd1,
      PLL_LOCKED    = 2'd2
   } pll_state_t;

   typedef enum logic [1:0] {
      TX_RST = 2'd0,
      TX_ANA = 2'd1,
      TX_UP  = 2'd2
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_RST  = 2'd0,
      RX_WAIT = 2'd1,
      RX_UP   = 2'd2
   } rx_state_t;

   localparam int RELOCK_W   = 8;
   localparam int SYNC_DEPTH = 2;

   localparam logic [RELOCK_W-1:0] RELOCK_MAX = '1;

endpackage

// File: rtl/qsfp_lane_seq.sv
// Single-lane TX and RX reset sequencer.
//   clk, rst_n          : clock and synchronous active-low reset
//   pll_ok              : shared PLL is locked (already synchronous)
//   lane_enable         : lane enable (synchronous)
//   tx_cal_busy,
//   rx_cal_busy,
//   rx_is_lockedtodata  : asynchronous PHY status, synchronized here
//   tx/rx_*reset        : registered PHY reset controls
//   tx_ready, rx_ready  : lane TX / RX fully out of reset
//   relock_count        : saturating count of CDR lock losses while up
module qsfp_lane_seq
   import qsfp_xcvr_pkg::*;
#(
   parameter int TX_DIG_DELAY = 200,
   parameter int LOCK_STABLE  = 10000,
   parameter int LOCK_TIMEOUT = 100000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                pll_ok,
   input  logic                lane_enable,
   input  logic                tx_cal_busy,
   input  logic                rx_cal_busy,
   input  logic                rx_is_lockedtodata,
   output logic                tx_analogreset,
   output logic                tx_digitalreset,
   output logic                rx_analogreset,
   output logic                rx_digitalreset,
   output logic                tx_ready,
   output logic                rx_ready,
   output logic [RELOCK_W-1:0] relock_count
);

   localparam int TX_CW  = $clog2(TX_DIG_DELAY + 1);
   localparam int STB_CW = $clog2(LOCK_STABLE + 1);
   localparam int TO_CW  = $clog2(LOCK_TIMEOUT + 1);

   logic [SYNC_DEPTH-1:0] tx_busy_meta;
   logic [SYNC_DEPTH-1:0] rx_busy_meta;
   logic [SYNC_DEPTH-1:0] lock_meta;
   logic                  tx_busy_sync;
   logic                  rx_busy_sync;
   logic                  lock_sync;

   tx_state_t             tx_state;
   rx_state_t             rx_state;
   logic [TX_CW-1:0]      tx_cnt;
   logic [STB_CW-1:0]     stable_cnt;
   logic [TO_CW-1:0]      timeout_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tx_busy_meta <= '0;
         rx_busy_meta <= '0;
         lock_meta    <= '0;
      end else begin
         tx_busy_meta <= {tx_busy_meta[SYNC_DEPTH-2:0], tx_cal_busy};
         rx_busy_meta <= {rx_busy_meta[SYNC_DEPTH-2:0], rx_cal_busy};
         lock_meta    <= {lock_meta[SYNC_DEPTH-2:0], rx_is_lockedtodata};
      end
   end

   assign tx_busy_sync = tx_busy_meta[SYNC_DEPTH-1];
   assign rx_busy_sync = rx_busy_meta[SYNC_DEPTH-1];
   assign lock_sync    = lock_meta[SYNC_DEPTH-1];

   // TX: analog release once the PLL is up and calibration is idle, digital
   // release TX_DIG_DELAY cycles later. Losing the PLL or the enable drops
   // the lane straight back into full reset.
   always_ff @(posedge clk) begin
      if (!rst_n || !pll_ok || !lane_enable) begin
         tx_state        <= TX_RST;
         tx_cnt          <= '0;
         tx_analogreset  <= 1'b1;
         tx_digitalreset <= 1'b1;
         tx_ready        <= 1'b0;
      end else begin
         case (tx_state)
            TX_RST: begin
               if (!tx_busy_sync) begin
                  tx_state       <= TX_ANA;
                  tx_cnt         <= '0;
                  tx_analogreset <= 1'b0;
               end
            end
            TX_ANA: begin
               if (tx_cnt == TX_CW'(TX_DIG_DELAY - 1)) begin
                  tx_state        <= TX_UP;
                  tx_digitalreset <= 1'b0;
                  tx_ready        <= 1'b1;
               end else begin
                  tx_cnt <= tx_cnt + 1'b1;
               end
            end
            TX_UP: begin
               tx_state <= TX_UP;
            end
            default: begin
               tx_state        <= TX_RST;
               tx_cnt          <= '0;
               tx_analogreset  <= 1'b1;
               tx_digitalreset <= 1'b1;
               tx_ready        <= 1'b0;
            end
         endcase
      end
   end

   // RX: independent of the PLL. The CDR must hold lock for LOCK_STABLE
   // consecutive cycles before digital release; if that never happens within
   // LOCK_TIMEOUT the analog reset is pulsed and the wait restarts. A lock
   // loss while up is counted, but only when the lane is still enabled, so a
   // coincident enable drop is never counted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_state        <= RX_RST;
         stable_cnt      <= '0;
         timeout_cnt     <= '0;
         rx_analogreset  <= 1'b1;
         rx_digitalreset <= 1'b1;
         rx_ready        <= 1'b0;
         relock_count    <= '0;
      end else if (!lane_enable) begin
         rx_state        <= RX_RST;
         stable_cnt      <= '0;
         timeout_cnt     <= '0;
         rx_analogreset  <= 1'b1;
         rx_digitalreset <= 1'b1;
         rx_ready        <= 1'b0;
      end else begin
         case (rx_state)
            RX_RST: begin
               if (!rx_busy_sync) begin
                  rx_state       <= RX_WAIT;
                  stable_cnt     <= '0;
                  timeout_cnt    <= '0;
                  rx_analogreset <= 1'b0;
               end
            end
            RX_WAIT: begin
               if (lock_sync && (stable_cnt == STB_CW'(LOCK_STABLE - 1))) begin
                  rx_state        <= RX_UP;
                  rx_digitalreset <= 1'b0;
                  rx_ready        <= 1'b1;
               end else if (timeout_cnt == TO_CW'(LOCK_TIMEOUT - 1)) begin
                  rx_state       <= RX_RST;
                  rx_analogreset <= 1'b1;
               end else begin
                  stable_cnt  <= lock_sync ? stable_cnt + 1'b1 : '0;
                  timeout_cnt <= timeout_cnt + 1'b1;
               end
            end
            RX_UP: begin
               if (!lock_sync) begin
                  rx_state        <= RX_RST;
                  rx_analogreset  <= 1'b1;
                  rx_digitalreset <= 1'b1;
                  rx_ready        <= 1'b0;
                  if (relock_count != RELOCK_MAX) begin
                     relock_count <= relock_count + 1'b1;
                  end
               end
            end
            default: begin
               rx_state        <= RX_RST;
               rx_analogreset  <= 1'b1;
               rx_digitalreset <= 1'b1;
               rx_ready        <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/qsfp_xcvr_reset_seq.sv
// Reset/bring-up sequencer for the QSFP transceiver lanes and shared ATX PLL.
//   clk_100_clk, reset_100_reset_n : 100 MHz clock, synchronous active-low reset
//   pll_locked                     : ATX PLL lock (asynchronous)
//   lane_enable                    : per-lane enable (synchronous)
//   tx_cal_busy, rx_cal_busy,
//   rx_is_lockedtodata             : per-lane PHY status (asynchronous)
//   pll_powerdown                  : ATX PLL powerdown
//   tx/rx_analogreset, tx/rx_digitalreset, tx_ready, rx_ready : per lane
//   relock_count                   : per-lane lock-loss count, lane i at [8i+7:8i]
module qsfp_xcvr_reset_seq
   import qsfp_xcvr_pkg::*;
#(
   parameter int NUM_LANES     = 4,
   parameter int PLL_PD_CYCLES = 1000,
   parameter int TX_DIG_DELAY  = 200,
   parameter int LOCK_STABLE   = 10000,
   parameter int LOCK_TIMEOUT  = 100000
) (
   input  logic                          clk_100_clk,
   input  logic                          reset_100_reset_n,
   input  logic                          pll_locked,
   input  logic [NUM_LANES-1:0]          lane_enable,
   input  logic [NUM_LANES-1:0]          tx_cal_busy,
   input  logic [NUM_LANES-1:0]          rx_cal_busy,
   input  logic [NUM_LANES-1:0]          rx_is_lockedtodata,
   output logic                          pll_powerdown,
   output logic [NUM_LANES-1:0]          tx_analogreset,
   output logic [NUM_LANES-1:0]          tx_digitalreset,
   output logic [NUM_LANES-1:0]          rx_analogreset,
   output logic [NUM_LANES-1:0]          rx_digitalreset,
   output logic [NUM_LANES-1:0]          tx_ready,
   output logic [NUM_LANES-1:0]          rx_ready,
   output logic [RELOCK_W*NUM_LANES-1:0] relock_count
);

   localparam int PD_CW = $clog2(PLL_PD_CYCLES + 1);

   logic [SYNC_DEPTH-1:0] pll_locked_meta;
   logic                  pll_locked_sync;
   pll_state_t            pll_state;
   logic [PD_CW-1:0]      pd_cnt;
   logic                  pll_ok;

   always_ff @(posedge clk_100_clk) begin
      if (!reset_100_reset_n) begin
         pll_locked_meta <= '0;
      end else begin
         pll_locked_meta <= {pll_locked_meta[SYNC_DEPTH-2:0], pll_locked};
      end
   end

   assign pll_locked_sync = pll_locked_meta[SYNC_DEPTH-1];

   // Powerdown is held for PLL_PD_CYCLES cycles after reset release and is
   // never reasserted by a later lock loss; only lock is re-awaited.
   always_ff @(posedge clk_100_clk) begin
      if (!reset_100_reset_n) begin
         pll_state     <= PLL_PD;
         pd_cnt        <= '0;
         pll_powerdown <= 1'b1;
      end else begin
         case (pll_state)
            PLL_PD: begin
               if (pd_cnt == PD_CW'(PLL_PD_CYCLES - 1)) begin
                  pll_state     <= PLL_WAIT_LOCK;
                  pll_powerdown <= 1'b0;
               end else begin
                  pd_cnt <= pd_cnt + 1'b1;
               end
            end
            PLL_WAIT_LOCK: begin
               if (pll_locked_sync) pll_state <= PLL_LOCKED;
            end
            PLL_LOCKED: begin
               if (!pll_locked_sync) pll_state <= PLL_WAIT_LOCK;
            end
            default: begin
               pll_state     <= PLL_PD;
               pd_cnt        <= '0;
               pll_powerdown <= 1'b1;
            end
         endcase
      end
   end

   assign pll_ok = (pll_state == PLL_LOCKED);

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      qsfp_lane_seq #(
         .TX_DIG_DELAY (TX_DIG_DELAY),
         .LOCK_STABLE  (LOCK_STABLE),
         .LOCK_TIMEOUT (LOCK_TIMEOUT)
      ) u_lane (
         .clk                (clk_100_clk),
         .rst_n              (reset_100_reset_n),
         .pll_ok             (pll_ok),
         .lane_enable        (lane_enable[i]),
         .tx_cal_busy        (tx_cal_busy[i]),
         .rx_cal_busy        (rx_cal_busy[i]),
         .rx_is_lockedtodata (rx_is_lockedtodata[i]),
         .tx_analogreset     (tx_analogreset[i]),
         .tx_digitalreset    (tx_digitalreset[i]),
         .rx_analogreset     (rx_analogreset[i]),
         .rx_digitalreset    (rx_digitalreset[i]),
         .tx_ready           (tx_ready[i]),
         .rx_ready           (rx_ready[i]),
         .relock_count       (relock_count[RELOCK_W*i +: RELOCK_W])
      );
   end

endmodule

// File: tb/tb_qsfp_xcvr_reset_seq.sv
// Directed bench for qsfp_xcvr_reset_seq. Expected event latencies (in
// clock edges from the driving step) are queued when stimulus is applied
// and popped when the corresponding output edge is observed.
module tb_qsfp_xcvr_reset_seq;

   localparam int N = 4;
   localparam int P = 4;
   localparam int D = 8;
   localparam int S = 16;
   localparam int T = 64;

   localparam int SEL_PD  = 0;
   localparam int SEL_TXA = 1;
   localparam int SEL_TXD = 2;
   localparam int SEL_RXA = 3;
   localparam int SEL_RXD = 4;
   localparam int SEL_TXR = 5;
   localparam int SEL_RXR = 6;

   logic           clk = 1'b0;
   logic           reset_n;
   logic           pll_locked;
   logic [N-1:0]   lane_enable;
   logic [N-1:0]   tx_cal_busy;
   logic [N-1:0]   rx_cal_busy;
   logic [N-1:0]   lock;
   logic           pll_powerdown;
   logic [N-1:0]   tx_analogreset;
   logic [N-1:0]   tx_digitalreset;
   logic [N-1:0]   rx_analogreset;
   logic [N-1:0]   rx_digitalreset;
   logic [N-1:0]   tx_ready;
   logic [N-1:0]   rx_ready;
   logic [8*N-1:0] relock_count;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q[$];
   int t_a, t_b, t_c, t_d, t_e;

   always #5 clk = ~clk;

   qsfp_xcvr_reset_seq #(
      .NUM_LANES     (N),
      .PLL_PD_CYCLES (P),
      .TX_DIG_DELAY  (D),
      .LOCK_STABLE   (S),
      .LOCK_TIMEOUT  (T)
   ) dut (
      .clk_100_clk        (clk),
      .reset_100_reset_n  (reset_n),
      .pll_locked         (pll_locked),
      .lane_enable        (lane_enable),
      .tx_cal_busy        (tx_cal_busy),
      .rx_cal_busy        (rx_cal_busy),
      .rx_is_lockedtodata (lock),
      .pll_powerdown      (pll_powerdown),
      .tx_analogreset     (tx_analogreset),
      .tx_digitalreset    (tx_digitalreset),
      .rx_analogreset     (rx_analogreset),
      .rx_digitalreset    (rx_digitalreset),
      .tx_ready           (tx_ready),
      .rx_ready           (rx_ready),
      .relock_count       (relock_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_pop(input string tag, input logic [31:0] obs);
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $error("FAIL %s observed=%0d expected=<queue empty>", tag, obs);
      end else begin
         check(tag, obs, exp_q.pop_front());
      end
   endtask

   function automatic logic get_bit(input int sel, input int ln);
      case (sel)
         SEL_PD:  return pll_powerdown;
         SEL_TXA: return tx_analogreset[ln];
         SEL_TXD: return tx_digitalreset[ln];
         SEL_RXA: return rx_analogreset[ln];
         SEL_RXD: return rx_digitalreset[ln];
         SEL_TXR: return tx_ready[ln];
         default: return rx_ready[ln];
      endcase
   endfunction

   // Count clock edges until the selected output bit first equals val;
   // -1 when the budget runs out.
   task automatic wait_evt(input int sel, input int ln, input logic val,
                           input int budget, output int lat);
      lat = -1;
      for (int k = 1; k <= budget; k++) begin
         @(negedge clk);
         if (get_bit(sel, ln) === val) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic check_reset_vals(input string pfx);
      check({pfx, "_pd"},     {31'd0, pll_powerdown}, 32'd1);
      check({pfx, "_txa"},    {28'd0, tx_analogreset}, 32'hF);
      check({pfx, "_txd"},    {28'd0, tx_digitalreset}, 32'hF);
      check({pfx, "_rxa"},    {28'd0, rx_analogreset}, 32'hF);
      check({pfx, "_rxd"},    {28'd0, rx_digitalreset}, 32'hF);
      check({pfx, "_txrdy"},  {28'd0, tx_ready}, 32'h0);
      check({pfx, "_rxrdy"},  {28'd0, rx_ready}, 32'h0);
      check({pfx, "_relock"}, relock_count, 32'h0);
   endtask

   initial begin
      reset_n     = 1'b0;
      pll_locked  = 1'b0;
      lane_enable = '1;
      tx_cal_busy = 4'b0100;
      rx_cal_busy = '0;
      lock        = '1;
      repeat (3) @(negedge clk);
      check_reset_vals("rst");

      // Bring-up: powerdown falls after P edges, pll_locked rises after edge
      // 10, PLL locked at edge 13 (2 sync + 1), TX analog release edge 14,
      // digital release D later. RX: lock seen from edge 3, ready at 3+S-1.
      reset_n = 1'b1;
      exp_q.push_back(32'd4);
      exp_q.push_back(32'd14);
      exp_q.push_back(32'd22);
      exp_q.push_back(32'd22);
      exp_q.push_back(32'd18);
      fork
         begin repeat (10) @(negedge clk); pll_locked = 1'b1; end
         wait_evt(SEL_PD,  0, 1'b0, 60, t_a);
         wait_evt(SEL_TXA, 0, 1'b0, 60, t_b);
         wait_evt(SEL_TXD, 0, 1'b0, 60, t_c);
         wait_evt(SEL_TXR, 0, 1'b1, 60, t_d);
         wait_evt(SEL_RXR, 0, 1'b1, 60, t_e);
      join
      check_pop("up_pd_fall", t_a);
      check_pop("up_txa0_fall", t_b);
      check_pop("up_txd0_fall", t_c);
      check_pop("up_txrdy0", t_d);
      check_pop("up_rxrdy0", t_e);
      check("up_txrdy_busy2", {28'd0, tx_ready}, 32'b1011);
      check("up_txa_busy2", {28'd0, tx_analogreset}, 32'b0100);
      check("up_rxrdy_all", {28'd0, rx_ready}, 32'hF);

      // Lane 2 calibration done: analog release 3 edges later, ready D after.
      tx_cal_busy = '0;
      exp_q.push_back(32'd3);
      exp_q.push_back(32'd3 + D);
      fork
         wait_evt(SEL_TXA, 2, 1'b0, 40, t_a);
         wait_evt(SEL_TXR, 2, 1'b1, 40, t_b);
      join
      check_pop("cal2_txa_fall", t_a);
      check_pop("cal2_txrdy", t_b);
      check("cal2_txrdy_all", {28'd0, tx_ready}, 32'hF);

      // Lane 1 lock dropped for 5 cycles: reset at edge 3, lock seen again
      // from edge 8, ready S edges of stable lock later (edge 23).
      lock[1] = 1'b0;
      exp_q.push_back(32'd3);
      exp_q.push_back(32'd3);
      exp_q.push_back(32'd23);
      fork
         wait_evt(SEL_RXA, 1, 1'b1, 40, t_a);
         begin
            wait_evt(SEL_RXR, 1, 1'b0, 40, t_b);
            wait_evt(SEL_RXR, 1, 1'b1, 60, t_c);
            t_c = (t_b < 0 || t_c < 0) ? -1 : t_b + t_c;
         end
         begin repeat (5) @(negedge clk); lock[1] = 1'b1; end
      join
      check_pop("l1_rxa_rise", t_a);
      check_pop("l1_rxrdy_fall", t_b);
      check_pop("l1_rxrdy_relock", t_c);
      check("l1_relock_cnt", relock_count, 32'h0000_0100);

      // Lane 0 disabled (immediate reset, no count), then re-enabled with no
      // CDR lock: analog reset pulses for one cycle every T+1 cycles.
      lane_enable[0] = 1'b0;
      lock[0]        = 1'b0;
      exp_q.push_back(32'd1);
      exp_q.push_back(32'd1);
      fork
         wait_evt(SEL_TXR, 0, 1'b0, 10, t_a);
         wait_evt(SEL_RXA, 0, 1'b1, 10, t_b);
      join
      check_pop("l0_dis_txrdy", t_a);
      check_pop("l0_dis_rxa", t_b);
      repeat (4) @(negedge clk);
      lane_enable[0] = 1'b1;
      exp_q.push_back(32'd1);
      exp_q.push_back(32'd1 + T);
      exp_q.push_back(32'd2 + T);
      exp_q.push_back(32'd2 + 2 * T);
      wait_evt(SEL_RXA, 0, 1'b0, 100, t_a);
      wait_evt(SEL_RXA, 0, 1'b1, 100, t_b);
      wait_evt(SEL_RXA, 0, 1'b0, 100, t_c);
      wait_evt(SEL_RXA, 0, 1'b1, 100, t_d);
      check_pop("l0_to_fall1", t_a);
      check_pop("l0_to_rise1", t_a + t_b);
      check_pop("l0_to_fall2", t_a + t_b + t_c);
      check_pop("l0_to_rise2", t_a + t_b + t_c + t_d);
      check("l0_to_relock", relock_count, 32'h0000_0100);

      // PLL lock lost: 2 sync + PLL FSM + lane FSM = 4 edges to TX reset.
      pll_locked = 1'b0;
      exp_q.push_back(32'd4);
      exp_q.push_back(32'd4);
      fork
         wait_evt(SEL_TXR, 3, 1'b0, 20, t_a);
         wait_evt(SEL_TXA, 1, 1'b1, 20, t_b);
      join
      check_pop("plldrop_txrdy3", t_a);
      check_pop("plldrop_txa1", t_b);
      check("plldrop_txa_all", {28'd0, tx_analogreset}, 32'hF);
      check("plldrop_txd_all", {28'd0, tx_digitalreset}, 32'hF);
      check("plldrop_rx_up", {29'd0, rx_ready[3:1]}, 32'd7);
      check("plldrop_pd", {31'd0, pll_powerdown}, 32'd0);
      pll_locked = 1'b1;
      exp_q.push_back(32'd4);
      exp_q.push_back(32'd4 + D);
      fork
         wait_evt(SEL_TXA, 1, 1'b0, 30, t_a);
         wait_evt(SEL_TXR, 1, 1'b1, 30, t_b);
      join
      check_pop("pllback_txa1", t_a);
      check_pop("pllback_txrdy1", t_b);
      check("pllback_txrdy_all", {28'd0, tx_ready}, 32'hF);

      // Lane 1 lock loss and enable drop reach the FSM on the same edge.
      lock[1] = 1'b0;
      repeat (2) @(negedge clk);
      lane_enable[1] = 1'b0;
      repeat (4) @(negedge clk);
      check("simul_relock", relock_count, 32'h0000_0100);
      check("simul_rxa1", {31'd0, rx_analogreset[1]}, 32'd1);
      check("simul_rxrdy1", {31'd0, rx_ready[1]}, 32'd0);
      lock[1]        = 1'b1;
      lane_enable[1] = 1'b1;

      // 300 lock losses on lane 3; counter saturates at 255.
      for (int n = 1; n <= 300; n++) begin
         lock[3] = 1'b0;
         repeat (4) @(negedge clk);
         lock[3] = 1'b1;
         wait_evt(SEL_RXR, 3, 1'b1, 60, t_a);
         exp_q.push_back(32'd1);
         check_pop("l3_relocked", {31'd0, (t_a > 0)});
         if (n == 1 || n == 254 || n == 255 || n == 256 || n == 300) begin
            check("l3_relock_cnt", {24'd0, relock_count[31:24]}, (n > 255) ? 32'd255 : n);
         end
      end

      lane_enable[3] = 1'b0;
      repeat (3) @(negedge clk);
      check("l3_dis_resets",
            {28'd0, tx_analogreset[3], tx_digitalreset[3], rx_analogreset[3], rx_digitalreset[3]},
            32'hF);
      check("l3_dis_rdy", {30'd0, tx_ready[3], rx_ready[3]}, 32'd0);
      check("l3_dis_relock", {24'd0, relock_count[31:24]}, 32'd255);

      // Reset in the middle of lane 3's TX sequence.
      lane_enable[3] = 1'b1;
      repeat (5) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      check_reset_vals("midrst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
